// File: rtl/tick_btn_ctrl.sv
// -----------------------------------------------------------------------------
// tick_btn_ctrl
//   Upstream control stage for the minute/second counter chain. Generates the
//   EN / INC / CLR stimulus the counter consumes:
//     - EN  : one-cycle tick every CLK_DIV cycles while RUN=1
//     - INC : debounced set-button pulse with auto-repeat while held
//     - CLR : debounced one-shot clear pulse, which overrides EN/INC
//
// Ports
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-low reset
//   RUN      in   1 = prescaler advances, 0 = prescaler holds
//   BTN_INC  in   raw set button (asynchronous, bouncing)
//   BTN_CLR  in   raw clear button (asynchronous, bouncing)
//   EN       out  registered one-cycle tick
//   INC      out  registered one-cycle increment pulse
//   CLR      out  registered one-cycle clear pulse
// -----------------------------------------------------------------------------
module tick_btn_ctrl #(
  parameter int CLK_DIV      = 50000000,
  parameter int DEB_CYCLES   = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic RUN,
  input  logic BTN_INC,
  input  logic BTN_CLR,
  output logic EN,
  output logic INC,
  output logic CLR
);

  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PCNT_W  = $clog2(CLK_DIV);
  localparam int RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W  = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLK_DIV - 1);
  localparam logic [RCNT_W-1:0] DLY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RPT_LAST  = RCNT_W'(REPEAT_RATE - 1);

  // Button lane indices inside the per-button vectors
  localparam int B_INC = 0;
  localparam int B_CLR = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [1:0]        raw_s;
  logic [1:0]        sync1_r;
  logic [1:0]        sync2_r;
  logic [1:0]        db_r;
  logic [1:0]        db_prev_r;
  logic [DEB_W-1:0]  deb_cnt_r [2];
  logic [PCNT_W-1:0] pcnt_r;
  logic [RCNT_W-1:0] rcnt_r;
  state_t            state_r;

  logic db_inc_s;
  logic db_clr_s;
  logic inc_rise_s;
  logic clr_rise_s;

  assign raw_s      = {BTN_CLR, BTN_INC};
  assign db_inc_s   = db_r[B_INC];
  assign db_clr_s   = db_r[B_CLR];
  assign inc_rise_s = db_r[B_INC] & ~db_prev_r[B_INC];
  assign clr_rise_s = db_r[B_CLR] & ~db_prev_r[B_CLR];

  // Two-flop synchronisers and per-button debounce counters
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_r   <= 2'b00;
      sync2_r   <= 2'b00;
      db_r      <= 2'b00;
      db_prev_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_r[i] <= {DEB_W{1'b0}};
      end
    end else begin
      sync1_r   <= raw_s;
      sync2_r   <= sync1_r;
      db_prev_r <= db_r;
      for (int i = 0; i < 2; i++) begin
        // The level only flips after DEB_CYCLES back-to-back disagreeing
        // samples; a single agreeing sample restarts the count.
        if (sync2_r[i] != db_r[i]) begin
          if (deb_cnt_r[i] == DEB_LAST) begin
            db_r[i]      <= sync2_r[i];
            deb_cnt_r[i] <= {DEB_W{1'b0}};
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + {{(DEB_W-1){1'b0}}, 1'b1};
          end
        end else begin
          deb_cnt_r[i] <= {DEB_W{1'b0}};
        end
      end
    end
  end

  // Prescaler and EN tick; a held clear pins the prescaler at zero
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pcnt_r <= {PCNT_W{1'b0}};
      EN     <= 1'b0;
    end else if (db_clr_s) begin
      pcnt_r <= {PCNT_W{1'b0}};
      EN     <= 1'b0;
    end else if (RUN) begin
      if (pcnt_r == PCNT_LAST) begin
        pcnt_r <= {PCNT_W{1'b0}};
        EN     <= 1'b1;
      end else begin
        pcnt_r <= pcnt_r + {{(PCNT_W-1){1'b0}}, 1'b1};
        EN     <= 1'b0;
      end
    end else begin
      pcnt_r <= pcnt_r;
      EN     <= 1'b0;
    end
  end

  // One-shot CLR on each debounced clear press
  always_ff @(posedge CLK) begin
    if (!RST) begin
      CLR <= 1'b0;
    end else begin
      CLR <= clr_rise_s;
    end
  end

  // INC press / auto-repeat FSM. rcnt_r counts cycles elapsed since the last
  // INC pulse (0 in the cycle the pulse is visible), so the first repeat lands
  // exactly REPEAT_DELAY cycles after the press pulse and later ones every
  // REPEAT_RATE cycles.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= IDLE;
      rcnt_r  <= {RCNT_W{1'b0}};
      INC     <= 1'b0;
    end else if (db_clr_s) begin
      // Clear dominates: abort any hold; a new press edge is needed afterwards
      state_r <= IDLE;
      rcnt_r  <= {RCNT_W{1'b0}};
      INC     <= 1'b0;
    end else begin
      INC <= 1'b0;
      case (state_r)
        IDLE: begin
          rcnt_r <= {RCNT_W{1'b0}};
          if (inc_rise_s) begin
            INC     <= 1'b1;
            state_r <= DELAY;
          end else begin
            state_r <= IDLE;
          end
        end
        DELAY: begin
          if (!db_inc_s) begin
            state_r <= IDLE;
            rcnt_r  <= {RCNT_W{1'b0}};
          end else if (rcnt_r == DLY_LAST) begin
            INC     <= 1'b1;
            rcnt_r  <= {RCNT_W{1'b0}};
            state_r <= REPEAT;
          end else begin
            rcnt_r  <= rcnt_r + {{(RCNT_W-1){1'b0}}, 1'b1};
          end
        end
        REPEAT: begin
          if (!db_inc_s) begin
            state_r <= IDLE;
            rcnt_r  <= {RCNT_W{1'b0}};
          end else if (rcnt_r == RPT_LAST) begin
            INC    <= 1'b1;
            rcnt_r <= {RCNT_W{1'b0}};
          end else begin
            rcnt_r <= rcnt_r + {{(RCNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= IDLE;
          rcnt_r  <= {RCNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_btn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tick_btn_ctrl
//   Self-checking bench for tick_btn_ctrl with small parameters. Inputs change
//   on the falling edge; a reference model evaluated on every rising edge
//   predicts EN/INC/CLR, which are compared on the following falling edge.
//   The model works from button sample histories, a running tick count and
//   absolute due-times for INC repeats.
// -----------------------------------------------------------------------------
module tb_tick_btn_ctrl;

  localparam int CLK_DIV      = 10;
  localparam int DEB_CYCLES   = 4;
  localparam int REPEAT_DELAY = 20;
  localparam int REPEAT_RATE  = 5;

  logic CLK;
  logic RST;
  logic RUN;
  logic BTN_INC;
  logic BTN_CLR;
  logic EN;
  logic INC;
  logic CLR;

  tick_btn_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .RUN     (RUN),
    .BTN_INC (BTN_INC),
    .BTN_CLR (BTN_CLR),
    .EN      (EN),
    .INC     (INC),
    .CLR     (CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;
  int en_seen, inc_seen, clr_seen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc_n, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit       q_inc [$];
  bit       q_clr [$];
  bit [1:0] m_db;
  bit [1:0] m_prev;
  bit       m_en, m_inc, m_clr;
  bit       armed;
  longint   edge_n  = 0;
  longint   due;
  longint   ticks;

  // New debounced level: flips only if the last DEB_CYCLES synchronised
  // samples all disagree with the current level. The synchronised sample
  // seen at this edge is the raw value captured two edges earlier.
  function automatic bit deb_next(input bit q[$], input bit db);
    int last;
    bit v;
    last = q.size() - 2;
    v    = q[last];
    if (v == db) return db;
    for (int k = 0; k < DEB_CYCLES; k++) begin
      if (q[last-k] != v) return db;
    end
    return v;
  endfunction

  task automatic model_reset();
    q_inc.delete();
    q_clr.delete();
    for (int k = 0; k < DEB_CYCLES + 2; k++) begin
      q_inc.push_back(1'b0);
      q_clr.push_back(1'b0);
    end
    m_db   = 2'b00;
    m_prev = 2'b00;
    m_en   = 1'b0;
    m_inc  = 1'b0;
    m_clr  = 1'b0;
    armed  = 1'b0;
    due    = 0;
    ticks  = 0;
  endtask

  initial model_reset();

  always @(posedge CLK) begin
    if (!RST) begin
      model_reset();
    end else begin
      m_clr = m_db[1] && !m_prev[1];
      if (m_db[1]) begin
        m_en  = 1'b0;
        m_inc = 1'b0;
        ticks = 0;
        armed = 1'b0;
      end else begin
        if (RUN) begin
          ticks++;
          m_en = ((ticks % CLK_DIV) == 0);
        end else begin
          m_en = 1'b0;
        end
        m_inc = 1'b0;
        if (!m_db[0]) begin
          armed = 1'b0;
        end else if (!m_prev[0]) begin
          m_inc = 1'b1;
          armed = 1'b1;
          due   = edge_n + REPEAT_DELAY;
        end else if (armed && edge_n == due) begin
          m_inc = 1'b1;
          due   = edge_n + REPEAT_RATE;
        end
      end
      m_prev  = m_db;
      m_db[0] = deb_next(q_inc, m_db[0]);
      m_db[1] = deb_next(q_clr, m_db[1]);
      q_inc.push_back(BTN_INC);
      q_clr.push_back(BTN_CLR);
      void'(q_inc.pop_front());
      void'(q_clr.pop_front());
    end
    edge_n++;
  end

  // Advance n cycles, checking all outputs after each rising edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cyc_n++;
      check_val("EN",  {31'd0, EN},  {31'd0, m_en});
      check_val("INC", {31'd0, INC}, {31'd0, m_inc});
      check_val("CLR", {31'd0, CLR}, {31'd0, m_clr});
      if (EN  === 1'b1) en_seen++;
      if (INC === 1'b1) inc_seen++;
      if (CLR === 1'b1) clr_seen++;
    end
  endtask

  task automatic clear_seen();
    en_seen  = 0;
    inc_seen = 0;
    clr_seen = 0;
  endtask

  initial begin
    RST = 1'b0; RUN = 1'b0; BTN_INC = 1'b0; BTN_CLR = 1'b0;
    clear_seen();
    cyc(3);

    // 1: free-running prescaler, then reset mid-run
    RST = 1'b1; RUN = 1'b1;
    clear_seen();
    cyc(35);
    check_val("t1_en_count", en_seen, 32'd3);
    RST = 1'b0; cyc(1);
    RST = 1'b1; cyc(25);

    // 2: bounces shorter than the debounce window
    clear_seen();
    for (int r = 0; r < 5; r++) begin
      BTN_INC = 1'b1; cyc(3);
      BTN_INC = 1'b0; cyc(2);
    end
    cyc(10);
    check_val("t2_inc_count", inc_seen, 32'd0);

    // 3: long hold with auto-repeat, then release
    BTN_INC = 1'b1; cyc(45);
    BTN_INC = 1'b0; cyc(20);

    // 4: clear press with RUN=1
    clear_seen();
    BTN_CLR = 1'b1; cyc(10);
    BTN_CLR = 1'b0; cyc(30);
    check_val("t4_clr_count", clr_seen, 32'd1);

    // 5: clear pulse landing on a repeat INC (press pulse at T6, repeats at
    //    T26, T31, T36; the clear sampled at T30 reaches CLR at T36)
    BTN_INC = 1'b1; cyc(30);
    BTN_CLR = 1'b1; cyc(8);
    BTN_CLR = 1'b0; cyc(25);
    BTN_INC = 1'b0; cyc(15);

    // 6: hold prescaler at 7 for 50 cycles, then resume
    RST = 1'b0; cyc(1);
    RST = 1'b1; RUN = 1'b1; cyc(7);
    clear_seen();
    RUN = 1'b0; cyc(50);
    check_val("t6_en_hold", en_seen, 32'd0);
    RUN = 1'b1; cyc(15);

    // Randomised segments: run toggling, presses, glitches, resets
    for (int s = 0; s < 180; s++) begin
      int len;
      len = $urandom_range(1, 40);
      RST = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      if (!RST) len = $urandom_range(1, 2);
      RUN     = ($urandom_range(0, 3) != 0);
      BTN_INC = $urandom_range(0, 1);
      BTN_CLR = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        // per-cycle bouncing burst
        for (int b = 0; b < len; b++) begin
          BTN_INC = $urandom_range(0, 1);
          BTN_CLR = $urandom_range(0, 1);
          cyc(1);
        end
      end else begin
        cyc(len);
      end
    end
    RST = 1'b1; BTN_INC = 1'b0; BTN_CLR = 1'b0; cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
